// File: rtl/ahb_resp_mux.sv
// AHB slave-to-master response multiplexer: registers the data-phase slave select and
// embeds a default slave that answers active transfers with an illegal select with ERROR.
module ahb_resp_mux #(
  parameter int CHANNEL_NUM = 4,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 8
) (
  input  logic                                HCLK,
  input  logic                                HRESETn,
  input  logic [CHANNEL_NUM-1:0]              hsel_addr,
  input  logic [1:0]                          htrans,
  input  logic                                hready_in,
  input  logic [CHANNEL_NUM-1:0][DATA_W-1:0]  slv_hrdata,
  input  logic [CHANNEL_NUM-1:0]              slv_hreadyout,
  input  logic [CHANNEL_NUM-1:0]              slv_hresp,
  input  logic                                err_clr,
  output logic [DATA_W-1:0]                   hrdata,
  output logic                                hready_out,
  output logic                                hresp,
  output logic [CNT_W-1:0]                    err_cnt,
  output logic [CHANNEL_NUM-1:0]              dsel
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               addr_onehot;
  logic               dsel_onehot;
  logic               err_start;
  logic               cnt_inc;
  logic [DATA_W-1:0]  mux_data;
  logic               mux_ready;
  logic               mux_resp;

  assign addr_onehot = ($countones(hsel_addr) == 1);
  assign dsel_onehot = ($countones(dsel) == 1);

  // An active transfer whose select is not one-hot is claimed by the default slave.
  assign err_start = hready_in && htrans[1] && !addr_onehot;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
      dsel  <= '0;
    end else begin
      state <= state_nxt;
      if (hready_in) begin
        dsel <= hsel_addr;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (err_start) state_nxt = ERR1;
      ERR1:    state_nxt = ERR2;
      ERR2:    state_nxt = err_start ? ERR1 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cnt_inc = (state_nxt == ERR1) && (state != ERR1);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= cnt_inc ? CNT_W'(1) : '0;
    end else if (cnt_inc && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  // AND-OR mux; only meaningful when dsel is one-hot, which the output stage enforces.
  always_comb begin
    mux_data  = '0;
    mux_ready = 1'b0;
    mux_resp  = 1'b0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (dsel[i]) begin
        mux_data  = mux_data | slv_hrdata[i];
        mux_ready = mux_ready | slv_hreadyout[i];
        mux_resp  = mux_resp | slv_hresp[i];
      end
    end
  end

  always_comb begin
    hrdata     = '0;
    hready_out = 1'b1;
    hresp      = 1'b0;
    case (state)
      ERR1: begin
        hready_out = 1'b0;
        hresp      = 1'b1;
      end
      ERR2: begin
        hresp = 1'b1;
      end
      default: begin
        // Idle/busy with no valid owner falls through to a zero-wait OKAY.
        if (dsel_onehot) begin
          hrdata     = mux_data;
          hready_out = mux_ready;
          hresp      = mux_resp;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Self-checking bench for ahb_resp_mux: per-cycle stimulus rows push the expected
// data-phase response into a scoreboard that is popped and compared at the falling edge.
module tb_ahb_resp_mux;

  localparam int CH = 4;
  localparam int DW = 32;
  localparam int CW = 2;

  localparam logic [DW-1:0] D0 = 32'h0000_C0DE;
  localparam logic [DW-1:0] D1 = 32'h1111_1111;
  localparam logic [DW-1:0] D2 = 32'hDEAD_BEEF;
  localparam logic [DW-1:0] D3 = 32'h3333_3333;
  localparam logic [1:0]    NS = 2'b10;
  localparam logic [1:0]    ID = 2'b00;

  logic                     HCLK = 1'b0;
  logic                     HRESETn = 1'b1;
  logic [CH-1:0]            hsel_addr = '0;
  logic [1:0]               htrans = 2'b00;
  logic                     hready_in;
  logic [CH-1:0][DW-1:0]    slv_hrdata;
  logic [CH-1:0]            slv_hreadyout = '1;
  logic [CH-1:0]            slv_hresp = '0;
  logic                     err_clr = 1'b0;
  logic [DW-1:0]            hrdata;
  logic                     hready_out;
  logic                     hresp;
  logic [CW-1:0]            err_cnt;
  logic [CH-1:0]            dsel;

  ahb_resp_mux #(.CHANNEL_NUM(CH), .DATA_W(DW), .CNT_W(CW)) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .hsel_addr     (hsel_addr),
    .htrans        (htrans),
    .hready_in     (hready_in),
    .slv_hrdata    (slv_hrdata),
    .slv_hreadyout (slv_hreadyout),
    .slv_hresp     (slv_hresp),
    .err_clr       (err_clr),
    .hrdata        (hrdata),
    .hready_out    (hready_out),
    .hresp         (hresp),
    .err_cnt       (err_cnt),
    .dsel          (dsel)
  );

  assign hready_in = hready_out;

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [CH-1:0] hsel;
    logic [1:0]    htrans;
    logic [CH-1:0] rdy;
    logic          clr;
    logic [DW-1:0] exp_d;
    logic          exp_rdy;
    logic          exp_resp;
    logic [CW-1:0] exp_cnt;
    logic [CH-1:0] exp_dsel;
  } row_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          rdy;
    logic          resp;
    logic [CW-1:0] cnt;
    logic [CH-1:0] ds;
  } exp_t;

  row_t stim[$];
  exp_t sb[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  // Row = address phase driven this cycle plus the response expected at this cycle's
  // falling edge (which belongs to the address phase of the previous row).
  task automatic add(input logic [CH-1:0] hsel, input logic [1:0] tr, input logic [CH-1:0] rdy,
                     input logic clr, input logic [DW-1:0] d, input logic r, input logic e,
                     input logic [CW-1:0] cnt, input logic [CH-1:0] ds);
    row_t s;
    s.hsel = hsel; s.htrans = tr; s.rdy = rdy; s.clr = clr;
    s.exp_d = d; s.exp_rdy = r; s.exp_resp = e; s.exp_cnt = cnt; s.exp_dsel = ds;
    stim.push_back(s);
  endtask

  task automatic drive_row();
    row_t s;
    exp_t x;
    s = stim.pop_front();
    hsel_addr     = s.hsel;
    htrans        = s.htrans;
    slv_hreadyout = s.rdy;
    err_clr       = s.clr;
    x.d = s.exp_d; x.rdy = s.exp_rdy; x.resp = s.exp_resp; x.cnt = s.exp_cnt; x.ds = s.exp_dsel;
    sb.push_back(x);
    @(negedge HCLK);
  endtask

  task automatic test_reset();
    exp_t x;
    int   n = 0;
    #1 HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    x.d = '0; x.rdy = 1'b1; x.resp = 1'b0; x.cnt = '0; x.ds = '0;
    sb.push_back(x);
    x = sb.pop_front();
    chk_cnt++;
    if ({hrdata, hready_out, hresp, err_cnt, dsel} !== {x.d, x.rdy, x.resp, x.cnt, x.ds})
      $display("FAIL reset_hold: got data=%h rdy=%b resp=%b cnt=%0d dsel=%b, want data=%h rdy=%b resp=%b cnt=%0d dsel=%b",
               hrdata, hready_out, hresp, err_cnt, dsel, x.d, x.rdy, x.resp, x.cnt, x.ds);
    else pass_cnt++;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    add('0, ID, '1, 0, '0, 1, 0, 0, '0);
    add('0, ID, '1, 0, '0, 1, 0, 0, '0);
    while (stim.size() != 0) begin
      drive_row();
      x = sb.pop_front();
      chk_cnt++;
      if ({hrdata, hready_out, hresp, err_cnt, dsel} !== {x.d, x.rdy, x.resp, x.cnt, x.ds})
        $display("FAIL reset_release step %0d: got data=%h rdy=%b resp=%b cnt=%0d dsel=%b, want data=%h rdy=%b resp=%b cnt=%0d dsel=%b",
                 n, hrdata, hready_out, hresp, err_cnt, dsel, x.d, x.rdy, x.resp, x.cnt, x.ds);
      else pass_cnt++;
      n++;
      if (stim.size() != 0) begin @(posedge HCLK); #1; end
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_nonseq();
    exp_t x;
    int   n = 0;
    add(4'b0100, NS, '1, 0, '0, 1, 0, 0, 4'b0000);
    add(4'b0000, ID, '1, 0, D2, 1, 0, 0, 4'b0100);
    add(4'b0001, NS, '1, 0, '0, 1, 0, 0, 4'b0000);
    add(4'b0000, ID, '1, 0, D0, 1, 0, 0, 4'b0001);
    while (stim.size() != 0) begin
      drive_row();
      x = sb.pop_front();
      chk_cnt++;
      if ({hrdata, hready_out, hresp, err_cnt, dsel} !== {x.d, x.rdy, x.resp, x.cnt, x.ds})
        $display("FAIL nonseq step %0d: got data=%h rdy=%b resp=%b cnt=%0d dsel=%b, want data=%h rdy=%b resp=%b cnt=%0d dsel=%b",
                 n, hrdata, hready_out, hresp, err_cnt, dsel, x.d, x.rdy, x.resp, x.cnt, x.ds);
      else pass_cnt++;
      n++;
      if (stim.size() != 0) begin @(posedge HCLK); #1; end
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_back_to_back();
    exp_t x;
    int   n = 0;
    slv_hresp = 4'b1000;
    add(4'b0001, NS, '1, 0, '0, 1, 0, 0, 4'b0000);
    add(4'b1000, NS, '1, 0, D0, 1, 0, 0, 4'b0001);
    add(4'b0000, ID, '1, 0, D3, 1, 1, 0, 4'b1000);
    add(4'b0000, ID, '1, 0, '0, 1, 0, 0, 4'b0000);
    while (stim.size() != 0) begin
      drive_row();
      x = sb.pop_front();
      chk_cnt++;
      if ({hrdata, hready_out, hresp, err_cnt, dsel} !== {x.d, x.rdy, x.resp, x.cnt, x.ds})
        $display("FAIL back_to_back step %0d: got data=%h rdy=%b resp=%b cnt=%0d dsel=%b, want data=%h rdy=%b resp=%b cnt=%0d dsel=%b",
                 n, hrdata, hready_out, hresp, err_cnt, dsel, x.d, x.rdy, x.resp, x.cnt, x.ds);
      else pass_cnt++;
      n++;
      if (stim.size() != 0) begin @(posedge HCLK); #1; end
    end
    @(posedge HCLK); #1;
    slv_hresp = '0;
  endtask

  task automatic test_wait_state();
    exp_t x;
    int   n = 0;
    add(4'b0010, NS, 4'b1111, 0, '0, 1, 0, 0, 4'b0000);
    add(4'b1000, NS, 4'b1101, 0, D1, 0, 0, 0, 4'b0010);
    add(4'b1000, NS, 4'b1101, 0, D1, 0, 0, 0, 4'b0010);
    add(4'b1000, NS, 4'b1101, 0, D1, 0, 0, 0, 4'b0010);
    add(4'b1000, NS, 4'b1111, 0, D1, 1, 0, 0, 4'b0010);
    add(4'b0000, ID, 4'b1111, 0, D3, 1, 0, 0, 4'b1000);
    add(4'b0000, ID, 4'b1111, 0, '0, 1, 0, 0, 4'b0000);
    while (stim.size() != 0) begin
      drive_row();
      x = sb.pop_front();
      chk_cnt++;
      if ({hrdata, hready_out, hresp, err_cnt, dsel} !== {x.d, x.rdy, x.resp, x.cnt, x.ds})
        $display("FAIL wait_state step %0d: got data=%h rdy=%b resp=%b cnt=%0d dsel=%b, want data=%h rdy=%b resp=%b cnt=%0d dsel=%b",
                 n, hrdata, hready_out, hresp, err_cnt, dsel, x.d, x.rdy, x.resp, x.cnt, x.ds);
      else pass_cnt++;
      n++;
      if (stim.size() != 0) begin @(posedge HCLK); #1; end
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_decode_err();
    exp_t x;
    int   n = 0;
    add(4'b0000, NS, '1, 0, '0, 1, 0, 0, 4'b0000);
    add(4'b0000, ID, '1, 0, '0, 0, 1, 1, 4'b0000);
    add(4'b0000, ID, '1, 0, '0, 1, 1, 1, 4'b0000);
    add(4'b0110, NS, '1, 0, '0, 1, 0, 1, 4'b0000);
    add(4'b0000, ID, '1, 0, '0, 0, 1, 2, 4'b0110);
    add(4'b0000, ID, '1, 0, '0, 1, 1, 2, 4'b0110);
    add(4'b0000, ID, '1, 0, '0, 1, 0, 2, 4'b0000);
    while (stim.size() != 0) begin
      drive_row();
      x = sb.pop_front();
      chk_cnt++;
      if ({hrdata, hready_out, hresp, err_cnt, dsel} !== {x.d, x.rdy, x.resp, x.cnt, x.ds})
        $display("FAIL decode_err step %0d: got data=%h rdy=%b resp=%b cnt=%0d dsel=%b, want data=%h rdy=%b resp=%b cnt=%0d dsel=%b",
                 n, hrdata, hready_out, hresp, err_cnt, dsel, x.d, x.rdy, x.resp, x.cnt, x.ds);
      else pass_cnt++;
      n++;
      if (stim.size() != 0) begin @(posedge HCLK); #1; end
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_saturate();
    exp_t x;
    int   n = 0;
    add('0, ID, '1, 1, '0, 1, 0, 2, '0);
    add('0, NS, '1, 0, '0, 1, 0, 0, '0);
    for (int k = 0; k < 4; k++) begin
      add('0, NS, '1, 0, '0, 0, 1, (k == 0) ? 2'd1 : (k == 1) ? 2'd2 : 2'd3, '0);
      add('0, NS, '1, 0, '0, 1, 1, (k == 0) ? 2'd1 : (k == 1) ? 2'd2 : 2'd3, '0);
    end
    add('0, NS, '1, 0, '0, 0, 1, 3, '0);
    add('0, NS, '1, 1, '0, 1, 1, 3, '0);
    add('0, ID, '1, 0, '0, 0, 1, 1, '0);
    add('0, ID, '1, 0, '0, 1, 1, 1, '0);
    add('0, ID, '1, 0, '0, 1, 0, 1, '0);
    while (stim.size() != 0) begin
      drive_row();
      x = sb.pop_front();
      chk_cnt++;
      if ({hrdata, hready_out, hresp, err_cnt, dsel} !== {x.d, x.rdy, x.resp, x.cnt, x.ds})
        $display("FAIL saturate step %0d: got data=%h rdy=%b resp=%b cnt=%0d dsel=%b, want data=%h rdy=%b resp=%b cnt=%0d dsel=%b",
                 n, hrdata, hready_out, hresp, err_cnt, dsel, x.d, x.rdy, x.resp, x.cnt, x.ds);
      else pass_cnt++;
      n++;
      if (stim.size() != 0) begin @(posedge HCLK); #1; end
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_reset_mid();
    exp_t x;
    int   n = 0;
    add('0, NS, '1, 0, '0, 1, 0, 1, '0);
    add('0, ID, '1, 0, '0, 0, 1, 2, '0);
    while (stim.size() != 0) begin
      drive_row();
      x = sb.pop_front();
      chk_cnt++;
      if ({hrdata, hready_out, hresp, err_cnt, dsel} !== {x.d, x.rdy, x.resp, x.cnt, x.ds})
        $display("FAIL reset_mid_pre step %0d: got data=%h rdy=%b resp=%b cnt=%0d dsel=%b, want data=%h rdy=%b resp=%b cnt=%0d dsel=%b",
                 n, hrdata, hready_out, hresp, err_cnt, dsel, x.d, x.rdy, x.resp, x.cnt, x.ds);
      else pass_cnt++;
      n++;
      if (stim.size() != 0) begin @(posedge HCLK); #1; end
    end
    // Now in ERR1: reset asynchronously, between clock edges.
    #2 HRESETn = 1'b0;
    #1;
    x.d = '0; x.rdy = 1'b1; x.resp = 1'b0; x.cnt = '0; x.ds = '0;
    sb.push_back(x);
    x = sb.pop_front();
    chk_cnt++;
    if ({hrdata, hready_out, hresp, err_cnt, dsel} !== {x.d, x.rdy, x.resp, x.cnt, x.ds})
      $display("FAIL reset_mid_async: got data=%h rdy=%b resp=%b cnt=%0d dsel=%b, want data=%h rdy=%b resp=%b cnt=%0d dsel=%b",
               hrdata, hready_out, hresp, err_cnt, dsel, x.d, x.rdy, x.resp, x.cnt, x.ds);
    else pass_cnt++;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    n = 0;
    add(4'b0001, NS, '1, 0, '0, 1, 0, 0, 4'b0000);
    add(4'b0000, ID, '1, 0, D0, 1, 0, 0, 4'b0001);
    add(4'b0000, ID, '1, 0, '0, 1, 0, 0, 4'b0000);
    while (stim.size() != 0) begin
      drive_row();
      x = sb.pop_front();
      chk_cnt++;
      if ({hrdata, hready_out, hresp, err_cnt, dsel} !== {x.d, x.rdy, x.resp, x.cnt, x.ds})
        $display("FAIL reset_mid_post step %0d: got data=%h rdy=%b resp=%b cnt=%0d dsel=%b, want data=%h rdy=%b resp=%b cnt=%0d dsel=%b",
                 n, hrdata, hready_out, hresp, err_cnt, dsel, x.d, x.rdy, x.resp, x.cnt, x.ds);
      else pass_cnt++;
      n++;
      if (stim.size() != 0) begin @(posedge HCLK); #1; end
    end
    @(posedge HCLK); #1;
  endtask

  initial begin
    slv_hrdata[0] = D0;
    slv_hrdata[1] = D1;
    slv_hrdata[2] = D2;
    slv_hrdata[3] = D3;
    test_reset();
    test_nonseq();
    test_back_to_back();
    test_wait_state();
    test_decode_err();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", pass_cnt, chk_cnt);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ahb_resp_mux.md
Name: ahb_resp_mux

Overview:
- Parametrised slave-to-master response multiplexer for the AHB interconnect. It replaces the purely combinational one-hot payload mux.
- Registers the address-phase slave select into the data phase, qualified by HREADY, so HRDATA/HREADYOUT/HRESP are routed from the slave that owns the current data phase.
- Embeds a default slave that gives the AHB two-cycle ERROR response for active transfers with no select or a multi-hot select, and counts decode errors.
- Sits between the slave ports and each master's response path, one instance per layer.

Parameters:
- CHANNEL_NUM, 4, number of slave channels (1..32).
- DATA_W, 32, HRDATA width (32/64/128).
- CNT_W, 8, decode-error counter width.

Ports:
- HCLK  input  1  bus clock.
- HRESETn  input  1  asynchronous active-low reset.
- hsel_addr  input  CHANNEL_NUM  address-phase slave select from decoder, one-hot expected.
- htrans  input  2  address-phase HTRANS.
- hready_in  input  1  global HREADY, top-level loopback of hready_out.
- slv_hrdata  input  CHANNEL_NUM x DATA_W  packed per-slave read data.
- slv_hreadyout  input  CHANNEL_NUM  per-slave HREADYOUT.
- slv_hresp  input  CHANNEL_NUM  per-slave HRESP (1 = ERROR).
- err_clr  input  1  synchronous clear of err_cnt.
- hrdata  output  DATA_W  muxed read data.
- hready_out  output  1  muxed HREADY.
- hresp  output  1  muxed HRESP.
- err_cnt  output  CNT_W  saturating decode-error count.
- dsel  output  CHANNEL_NUM  registered data-phase select (debug/arbiter use).

Behaviour:
- Reset (async, HRESETn=0):
  - dsel=0, FSM=IDLE, err_cnt=0.
  - Outputs hrdata=0, hready_out=1, hresp=0 while in reset and in the first cycle after release.
- Address-phase capture, on the HCLK rising edge when hready_in=1:
  - dsel <= hsel_addr.
  - act_q <= htrans[1].
  - When hready_in=0, dsel and act_q hold.
- Legal select, dsel one-hot (bit i set):
  - hrdata=slv_hrdata[i], hready_out=slv_hreadyout[i], hresp=slv_hresp[i].
  - Purely combinational from dsel, zero added latency.
- Illegal select, dsel zero or multi-hot, with act_q=0 (IDLE/BUSY): hrdata=0, hready_out=1, hresp=0. This is a zero-wait OKAY.
- Default-slave FSM:
  - IDLE: on capture with htrans[1]=1 and hsel_addr not one-hot -> ERR1 on the same edge; err_cnt increments.
  - ERR1: hready_out=0, hresp=1, hrdata=0. -> ERR2 unconditionally.
  - ERR2: hready_out=1, hresp=1, hrdata=0. The address phase presented here is captured normally. -> ERR1 if that capture is again an active illegal select, else -> IDLE.
  - In ERR1/ERR2, outputs come from the FSM, never from slave inputs.
- One-hot check: popcount==1, evaluated on hsel_addr at capture.
- err_cnt:
  - +1 per ERR1 entry.
  - Saturates at all-ones.
  - err_clr=1 clears. With err_clr and an increment in the same cycle, err_cnt=1.
- Slave wait states: while the selected slave drives hreadyout=0, dsel holds, so a stalled data phase keeps routing to the same slave even if hsel_addr changes.
- Back-to-back transfers to different slaves: on the edge ending slave A's data phase with hready=1, dsel switches to B. No bubble.
- Reset mid-transfer: FSM returns to IDLE immediately, outputs take reset values, and no partial ERROR pair is completed.
- CHANNEL_NUM=1: the one-hot check reduces to hsel_addr[0].

Test Plan:
- Reset release, htrans=IDLE, hsel_addr=0 -> hready_out=1, hresp=0, hrdata=0, err_cnt=0.
- NONSEQ to ch2 (hsel_addr=4'b0100), slv_hrdata[2]=32'hDEAD_BEEF, slv_hreadyout[2]=1 -> in the next cycle hrdata=32'hDEAD_BEEF, hready_out=1, hresp=0.
- Ch1 read with slv_hreadyout[1]=0 for 3 cycles while hsel_addr switches to ch3 -> dsel stays 4'b0010 for those 3 cycles. Ch3 data is routed only in the cycle after ch1 returns hreadyout=1.
- NONSEQ with hsel_addr=0 -> ERR1 (hready_out=0, hresp=1), then ERR2 (hready_out=1, hresp=1), then IDLE; err_cnt=1. Repeat with hsel_addr=4'b0110 -> err_cnt=2.
- With CNT_W=2: 5 illegal NONSEQs -> err_cnt stays 3. Then err_clr asserted together with a 6th illegal NONSEQ -> err_cnt=1.
- Assert HRESETn=0 during ERR1 -> hready_out=1, hresp=0 asynchronously. After release, a NONSEQ to ch0 completes normally.
